// File: rtl/twofish_host_ctrl.sv
// Host-side stream adapter for a 128-bit Twofish core: packs four 32-bit input
// words into a block, commands the core, and streams the 128-bit result back out.
// Optional busy watchdog with sticky err flag is enabled by defining TF_WATCHDOG_EN.
module twofish_host_ctrl #(
  parameter int WD_LIMIT = 1024
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key_in,
  input  logic         key_load,
  input  logic         mode_in,
  output logic [127:0] block,
  output logic [127:0] key,
  output logic         EnDe,
  output logic         Start,
  input  logic [127:0] o,
  input  logic         busy,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err
);

  typedef enum logic [2:0] {
    S_FILL,
    S_START,
    S_ARM,
    S_WAIT,
    S_DRAIN
`ifdef TF_WATCHDOG_EN
    ,
    S_ABORT
`endif
  } state_t;

  state_t        state_reg, state_next;
  logic [1:0]    wcnt_reg;
  logic [127:0]  block_reg;
  logic [127:0]  key_reg;
  logic [127:0]  result_reg;
  logic          ende_reg;
  logic [31:0]   result_w [4];
  logic          in_fire;
  logic          out_fire;
  logic          wd_expire;

  if (WD_LIMIT < 1) begin : g_wd_limit_check
    $error("twofish_host_ctrl: WD_LIMIT must be at least 1");
  end

  assign in_fire  = (state_reg == S_FILL) && in_valid;
  assign out_fire = (state_reg == S_DRAIN) && out_ready;

  // Result word 0 is the most significant 32 bits, matching the input packing.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_result_words
      assign result_w[gi] = result_reg[127 - 32*gi -: 32];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FILL:  if (in_valid && (wcnt_reg == 2'd3)) state_next = S_START;
      S_START: state_next = S_ARM;
      S_ARM:   state_next = S_WAIT;
      S_WAIT: begin
        if (!busy)          state_next = S_DRAIN;
`ifdef TF_WATCHDOG_EN
        else if (wd_expire) state_next = S_ABORT;
`endif
      end
      S_DRAIN: if (out_ready && (wcnt_reg == 2'd3)) state_next = S_FILL;
`ifdef TF_WATCHDOG_EN
      S_ABORT: state_next = S_FILL;
`endif
      default: state_next = S_FILL;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg  <= S_FILL;
      wcnt_reg   <= 2'd0;
      block_reg  <= '0;
      key_reg    <= '0;
      ende_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (in_fire) begin
        // Word n lands at bit offset (3-n)*32, i.e. {~n, 5'b0}.
        block_reg[{~wcnt_reg, 5'd0} +: 32] <= in_data;
        if (wcnt_reg == 2'd0) ende_reg <= mode_in;
      end
      // Key may only change between blocks, never under a partially filled one.
      if ((state_reg == S_FILL) && (wcnt_reg == 2'd0) && key_load) key_reg <= key_in;
      if (in_fire || out_fire) wcnt_reg <= wcnt_reg + 2'd1;
      if ((state_reg == S_WAIT) && !busy) result_reg <= o;
    end
  end

`ifdef TF_WATCHDOG_EN
  localparam int WD_W = (WD_LIMIT > 1) ? $clog2(WD_LIMIT) : 1;

  logic [WD_W-1:0] wd_cnt_reg;
  logic            err_reg;

  assign wd_expire = (state_reg == S_WAIT) && busy && (wd_cnt_reg == WD_W'(WD_LIMIT - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wd_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if ((state_reg == S_WAIT) && busy) wd_cnt_reg <= wd_cnt_reg + 1'b1;
      else                               wd_cnt_reg <= '0;
      if (state_reg == S_ABORT) err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

  assign in_ready  = (state_reg == S_FILL);
  assign out_valid = (state_reg == S_DRAIN);
  assign Start     = (state_reg == S_START);
  assign block     = block_reg;
  assign key       = key_reg;
  assign EnDe      = ende_reg;
  assign out_data  = result_w[wcnt_reg];

endmodule

// File: tb/tb_twofish_host_ctrl.sv
// Directed + randomized bench for twofish_host_ctrl with a behavioural core stub
// and a block-level reference model (word queues, key register, cycle-count latency).
module tb_twofish_host_ctrl;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key_in;
  logic         key_load;
  logic         mode_in;
  logic [127:0] block;
  logic [127:0] key;
  logic         EnDe;
  logic         Start;
  logic [127:0] o;
  logic         busy;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         err;

  int checks   = 0;
  int failures = 0;
  logic [127:0] key_m;   // model of the key the controller should present

  twofish_host_ctrl #(.WD_LIMIT(8)) dut (
    .Clk(Clk), .Reset(Reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .key_in(key_in), .key_load(key_load), .mode_in(mode_in), .block(block), .key(key),
    .EnDe(EnDe), .Start(Start), .o(o), .busy(busy), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; in_valid = 1'b0; key_load = 1'b0; out_ready = 1'b0;
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_start", Start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_block", block, 0);
    chk("rst_key", key, 0);
    chk("rst_ende", EnDe, 0);
    chk("rst_err", err, 0);
    key_m = '0;
    Reset = 1'b0;
    $display("reset applied");
  endtask

  // Feeds one block with random in_valid gaps. keymode: 0 none, 1 with first word,
  // 2 on an idle cycle before it. reset_at>=0 resets after that many words and returns.
  task automatic send_fill(input logic [127:0] blk, input logic mode, input int keymode,
                           input logic [127:0] knew, input int reset_at);
    int idx = 0;
    int guard = 0;
    logic v;
    if (keymode == 2) begin
      in_valid = 1'b0; key_in = knew; key_load = 1'b1;
      step();
      key_load = 1'b0; key_m = knew;
    end
    while (idx < 4 && guard < 200) begin
      if (idx == reset_at) begin
        do_reset();
        return;
      end
      v = ($urandom_range(0, 3) != 0);
      in_valid = v;
      in_data  = v ? blk[(3 - idx)*32 +: 32] : $urandom;
      mode_in  = (idx == 0) ? mode : ~mode;
      key_load = 1'b0;
      if (idx == 0 && v && keymode == 1) begin
        key_load = 1'b1; key_in = knew; key_m = knew;
      end else if (idx > 0 && $urandom_range(0, 2) == 0) begin
        key_load = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
      if (v) idx++;
      guard++;
      if (idx < 4) begin
        chk("fill_in_ready", in_ready, 1);
        chk("fill_start_low", Start, 0);
        chk("fill_out_valid", out_valid, 0);
      end
    end
    in_valid = 1'b0; key_load = 1'b0;
    chk("fill_guard", (guard < 200), 1);
    chk("start_high", Start, 1);
    chk("start_block", block, blk);
    chk("start_key", key, key_m);
    chk("start_ende", EnDe, mode);
    chk("start_in_ready", in_ready, 0);
    $display("block in  blk=%h mode=%0d key=%h", blk, mode, key);
  endtask

  // Core stub plus result drain. Called at the negedge where Start is high.
  // busy stays high across L rising edges; out_valid must appear max(L+1,3) cycles later.
  task automatic core_drain(input int L, input logic [127:0] oval, input int stall_word,
                            input logic kpulse, input int reset_after);
    int first = (L + 1 > 3) ? L + 1 : 3;
    int idx = 0;
    int stall = 0;
    int guard = 0;
    logic rdy;
    busy = 1'b1;
    o = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 1; c < first; c++) begin
      step();
      key_load = 1'b0;
      chk("wait_out_valid", out_valid, 0);
      chk("wait_start_low", Start, 0);
      chk("wait_in_ready", in_ready, 0);
      if (c == L) begin
        busy = 1'b0; o = oval;
      end
      if (kpulse && c == 2) begin
        key_load = 1'b1; key_in = '1;
      end
    end
    step();
    key_load = 1'b0;
    o = {$urandom, $urandom, $urandom, $urandom};
    busy = $urandom_range(0, 1);
    if (kpulse) chk("wait_key_hold", key, key_m);
    while (idx < 4 && guard < 200) begin
      if (idx == reset_after) begin
        do_reset();
        return;
      end
      chk("drain_out_valid", out_valid, 1);
      chk("drain_out_data", out_data, oval[(3 - idx)*32 +: 32]);
      chk("drain_in_ready", in_ready, 0);
      if (idx == stall_word && stall < 5) begin
        rdy = 1'b0; stall++;
      end else begin
        rdy = ($urandom_range(0, 2) != 0);
      end
      out_ready = rdy;
      step();
      if (rdy) begin
        $display("word out  idx=%0d data=%h", idx, oval[(3 - idx)*32 +: 32]);
        idx++;
      end
      guard++;
    end
    out_ready = 1'b0; busy = 1'b0;
    chk("drain_guard", (guard < 200), 1);
    chk("refill_in_ready", in_ready, 1);
    chk("refill_out_valid", out_valid, 0);
  endtask

  initial begin
    logic [127:0] blk, oval, k;
    Reset = 1'b1; in_data = '0; in_valid = 1'b0; key_in = '0; key_load = 1'b0;
    mode_in = 1'b0; o = '0; busy = 1'b0; out_ready = 1'b0;
    step();
    do_reset();

    // Known-answer block: zero key, zero plaintext, encrypt.
    send_fill('0, 1'b0, 1, '0, -1);
    core_drain(4, 128'h9F589F5CF6122C32B6BFEC2F2AE8C35A, -1, 1'b0, -1);

    // Decrypt block, then stall the second output word for five cycles.
    send_fill(128'h11111111222222223333333344444444, 1'b1, 0, '0, -1);
    core_drain(1, 128'h9F589F5CF6122C32B6BFEC2F2AE8C35A, 1, 1'b0, -1);

    // Reset mid-fill: the two early words must not reach the next block.
    send_fill(128'hAAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD, 1'b0, 0, '0, 2);
    send_fill(128'h0123456789ABCDEFFEDCBA9876543210, 1'b1, 2, 128'h00112233445566778899AABBCCDDEEFF, -1);
    // key_load during WAIT is ignored; next block keeps the old key.
    core_drain(5, 128'hCAFEBABEDEADBEEF0BADF00D12345678, -1, 1'b1, -1);
    send_fill(128'h55555555666666667777777788888888, 1'b0, 0, '0, -1);
    // Reset mid-drain; busy left stuck high must be ignored during the next fill.
    core_drain(2, 128'h1357924680ACE0FF0F1E2D3C4B5A6978, -1, 1'b0, 2);
    busy = 1'b1;

    for (int n = 0; n < 8; n++) begin
      blk  = {$urandom, $urandom, $urandom, $urandom};
      oval = {$urandom, $urandom, $urandom, $urandom};
      k    = {$urandom, $urandom, $urandom, $urandom};
      send_fill(blk, 1'($urandom_range(0, 1)), $urandom_range(0, 2), k, -1);
      core_drain($urandom_range(1, 6), oval, $urandom_range(0, 5) == 0 ? $urandom_range(0, 3) : -1,
                 1'($urandom_range(0, 1)), -1);
    end

`ifdef TF_WATCHDOG_EN
    send_fill(128'hDEADDEADDEADDEADDEADDEADDEADDEAD, 1'b0, 0, '0, -1);
    busy = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step();
      chk("wd_no_out_valid", out_valid, 0);
      if (c == 10) chk("wd_err_before", err, 0);
    end
    chk("wd_err_set", err, 1);
    chk("wd_in_ready", in_ready, 1);
    busy = 1'b0;
    $display("watchdog abort observed err=%0d", err);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/twofish_host_ctrl.md
TWOFISH_HOST_CTRL -- requirements
Module: twofish_host_ctrl

Interface
REQ-001 SHALL have parameter WD_LIMIT, default 1024, max cycles busy may stay high before watchdog abort (used only when TF_WATCHDOG_EN is defined).
REQ-002 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_data  input  32  plaintext/ciphertext word from host stream.
REQ-005 SHALL have ports in_valid input 1 / in_ready output 1  host input handshake; a word transfers when both are high on a clock edge.
REQ-006 SHALL have ports key_in input 128 / key_load input 1  key value and one-cycle load strobe.
REQ-007 SHALL have port mode_in  input  1  direction per block, 0 = encrypt, 1 = decrypt; sampled with the first word.
REQ-008 SHALL have ports block output 128 / key output 128 / EnDe output 1 / Start output 1  cipher-core command side.
REQ-009 SHALL have ports o input 128 / busy input 1  cipher-core result side.
REQ-010 SHALL have ports out_data output 32 / out_valid output 1 / out_ready input 1  result stream; a word transfers when out_valid and out_ready are both high.
REQ-011 SHALL have port err  output  1  sticky watchdog-abort flag.

Function
REQ-012 SHALL implement states FILL, START, ARM, WAIT, DRAIN, plus ABORT when TF_WATCHDOG_EN is defined.
REQ-013 FILL: in_ready=1; accept 4 words; word 0 -> block[127:96], word 3 -> block[31:0]; 2-bit word counter wraps 3->0; latch mode_in into EnDe on word 0; after word 3 go to START.
REQ-014 START: Start=1 for exactly one cycle; block, key, EnDe held stable from START until WAIT exits; next state ARM.
REQ-015 ARM: one cycle with busy ignored (covers the core's busy rise latency); next state WAIT.
REQ-016 WAIT: when busy=0, capture o into result register that cycle; go to DRAIN next cycle.
REQ-017 DRAIN: out_valid=1; out_data = result[127:96] first, then [95:64], [63:32], [31:0]; advance only on out_ready; hold out_data stable while out_valid & !out_ready; after 4th transfer go to FILL.
REQ-018 in_ready SHALL be 0 in every state except FILL; out_valid SHALL be 0 in every state except DRAIN.
REQ-019 key_load SHALL update the key register only in FILL with word counter 0; otherwise it is ignored (no mid-block key change).
REQ-020 key_load and the first-word in_valid transfer in the same cycle: new key applies to that block.
REQ-021 Latency: last input word accepted at edge N -> Start high in cycle N+1; first out_valid one cycle after the edge on which busy=0 is seen in WAIT.
REQ-022 Throughput: back-to-back blocks; FILL re-entered the cycle after the 4th output transfer.

Reset
REQ-023 On Reset=1 at a clock edge: state=FILL, word counter=0, in_ready=1 next cycle, Start=0, out_valid=0, out_data=0, block=0, key=0, EnDe=0, result=0, err=0.
REQ-024 Reset in any state, including mid-WAIT or mid-DRAIN, SHALL discard partial input/output words; core busy afterwards is ignored until the next START.

Configuration
REQ-025 With macro TF_WATCHDOG_EN defined: cycle counter runs in WAIT; if busy remains 1 for WD_LIMIT consecutive WAIT cycles, go to ABORT, set err=1, then return to FILL; no output words for that block; err cleared only by Reset.
REQ-026 Without TF_WATCHDOG_EN: no counter, no ABORT state, err tied to 0, WAIT waits indefinitely.

Verification
REQ-027 Reset, key_load key=0, 4 zero words mode=0, core stub returns o=128'h9F589F5CF6122C32B6BFEC2F2AE8C35A -> out words 9F589F5C, F6122C32, B6BFEC2F, 2AE8C35A in order, EnDe=0.
REQ-028 Input words 11111111,22222222,33333333,44444444 with mode=1 -> block=128'h11111111222222223333333344444444 at Start, EnDe=1, Start high exactly 1 cycle.
REQ-029 out_ready held 0 for 5 cycles during DRAIN word 1 -> out_data stays 0xF6122C32 with out_valid=1, in_ready=0 throughout.
REQ-030 Reset asserted after 2 input words -> next 4 words form a fresh block; the earlier 2 words never appear in block.
REQ-031 key_load pulse with key=128'hFF..FF during WAIT -> key output unchanged until next FILL with counter 0.
REQ-032 TF_WATCHDOG_EN defined, WD_LIMIT=8, core busy stuck 1 -> err=1 after 8 WAIT cycles, no out_valid, in_ready=1 afterwards.
